// File: rtl/keypad_pkg.sv
// Shared types and the key legend for the 4x4 matrix keypad scanner.
package keypad_pkg;

  // What one full scan frame saw across all 16 switches
  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } res_kind_e;

  // code is kept at 0 unless kind is RES_SINGLE, so whole-struct compares are meaningful
  typedef struct packed {
    res_kind_e  kind;
    logic [3:0] code;
  } frame_res_t;

  typedef enum logic {
    ST_RELEASED = 1'b0,
    ST_PRESSED  = 1'b1
  } key_state_e;

  // Printed legend of the Pmod KYPD: row-major, row 3 reads 0 F E D
  function automatic logic [3:0] key_legend(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for the pulled-up row sense lines; idles high (no key).
module key_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Double-register raw rows into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 4'hF;
      q    <= 4'hF;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column ring, per-frame closure tally, frame debounce,
// press/release FSM and a valid/ack key output with sticky overrun.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 20000,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] col_n,
  input  logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ack,
  output logic       key_held,
  output logic       overrun
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STAB_MAX   = SW'(DEBOUNCE_CNT);

  logic [DW-1:0] dwell;
  logic [1:0]    col;
  logic [3:0]    row_s;
  logic          sample, frame_end;

  logic [1:0]    acc_n;      // closures so far this frame, saturating at 2
  logic [3:0]    acc_code;   // code of the first closure seen this frame
  logic [2:0]    col_hits;
  logic [3:0]    col_code;
  logic [2:0]    tot;
  frame_res_t    fres;

  frame_res_t    prev, prev_nxt;
  logic [SW-1:0] stab, stab_nxt;
  logic          stable;
  key_state_e    state;

  key_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (row_s)
  );

  assign sample    = (dwell == DWELL_LAST);
  assign frame_end = sample && (col == 2'd3);

  // Dwell counter and one-cold column ring; advance after the sampling cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell <= '0;
      col   <= 2'd0;
      col_n <= 4'b1110;
    end else if (sample) begin
      dwell <= '0;
      col   <= col + 2'd1;
      col_n <= {col_n[2:0], col_n[3]};
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Closures in the current column and the running frame result including them
  always_comb begin
    col_hits = 3'd0;
    col_code = 4'h0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s[r]) begin
        if (col_hits == 3'd0) col_code = key_legend(2'(r), col);
        col_hits = col_hits + 3'd1;
      end
    end
    tot  = {1'b0, acc_n} + col_hits;
    fres = '{kind: RES_NONE, code: 4'h0};
    if (tot == 3'd1)
      fres = '{kind: RES_SINGLE, code: (acc_n == 2'd1) ? acc_code : col_code};
    else if (tot >= 3'd2)
      fres = '{kind: RES_MULTI, code: 4'h0};
  end

  // Frame accumulator: fold each column sample in, clear at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_n    <= 2'd0;
      acc_code <= 4'h0;
    end else if (frame_end) begin
      acc_n    <= 2'd0;
      acc_code <= 4'h0;
    end else if (sample) begin
      acc_n <= (tot >= 3'd2) ? 2'd2 : tot[1:0];
      if (acc_n == 2'd0 && col_hits != 3'd0) acc_code <= col_code;
    end
  end

  // Stability count over frames; MULTI frames leave everything untouched
  always_comb begin
    stab_nxt = stab;
    prev_nxt = prev;
    if (frame_end && fres.kind != RES_MULTI) begin
      if (fres == prev) begin
        stab_nxt = (stab == STAB_MAX) ? stab : stab + SW'(1);
      end else begin
        stab_nxt = SW'(1);
        prev_nxt = fres;
      end
    end
    stable = frame_end && (fres.kind != RES_MULTI) && (stab_nxt == STAB_MAX);
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab <= '0;
      prev <= '{kind: RES_NONE, code: 4'h0};
    end else begin
      stab <= stab_nxt;
      prev <= prev_nxt;
    end
  end

  // Press/release FSM with the key handshake; a press during a pending key is an overrun
  // unless that key is being acked on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RELEASED;
      key_held  <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      overrun   <= 1'b0;
    end else begin
      if (key_valid && key_ack) key_valid <= 1'b0;
      case (state)
        ST_RELEASED: begin
          if (stable && fres.kind == RES_SINGLE) begin
            state    <= ST_PRESSED;
            key_held <= 1'b1;
            if (!key_valid || key_ack) begin
              key_code  <= fres.code;
              key_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end
        ST_PRESSED: begin
          if (stable && fres.kind == RES_NONE) begin
            state    <= ST_RELEASED;
            key_held <= 1'b0;
          end
        end
        default: state <= ST_RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a 4x4 switch-matrix model and an expected-code queue.
module tb_keypad_scanner;

  localparam int SD    = 4;
  localparam int DB    = 3;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] col_n, row_n, key_code;
  logic       key_valid, key_ack, key_held, overrun;
  logic [3:0][3:0] keys;   // keys[row][col] = 1 means switch closed

  int tests = 0;
  int fails = 0;
  int taken = 0;
  int npres = 0;
  int cyc   = 0;
  int lat;
  logic [3:0] last_code = 4'h0;
  logic       vprev, aprev;
  logic [3:0] exp_q[$];
  logic [3:0] exp_col;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ack   (key_ack),
    .key_held  (key_held),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Keypad: a closed switch pulls its row low while its column is driven
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r][c] && !col_n[c]) row_n[r] = 1'b0;
  end

  // Posedges since reset release; frame ends land on multiples of FRAME
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Record each new key presentation (rise of valid, or reload on an acked edge)
  always @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      vprev <= 1'b0;
      aprev <= 1'b0;
    end else begin
      if (key_valid && (!vprev || aprev)) begin
        npres     <= npres + 1;
        last_code <= key_code;
      end
      vprev <= key_valid;
      aprev <= key_ack;
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    #1;
  endtask

  task automatic align_frame();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % FRAME != 0);
  endtask

  task automatic ack_pulse();
    @(posedge clk); #1 key_ack = 1'b1;
    @(posedge clk); #1 key_ack = 1'b0;
  endtask

  // Wait (bounded) for the next presentation and score it against the queue
  task automatic expect_key(input string tag, input int budget, output int n);
    logic [3:0] e;
    n = 0;
    while (npres == taken && n < budget) begin
      @(negedge clk);
      n++;
    end
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hX;
    chk({tag, "_presented"}, npres, taken + 1);
    chk({tag, "_code"}, last_code, e);
    taken = npres;
  endtask

  initial begin
    keys    = '0;
    key_ack = 1'b0;

    // Reset values and column stepping
    repeat (3) @(negedge clk);
    chk("rst_col_n", col_n, 4'b1110);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_held", key_held, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    exp_col = 4'b1110;
    chk("col_step0", col_n, exp_col);
    for (int k = 1; k <= 4; k++) begin
      repeat (SD) @(negedge clk);
      exp_col = {exp_col[2:0], exp_col[3]};
      chk("col_step", col_n, exp_col);
    end

    // Clean press of 6 at (r1,c2)
    align_frame();
    exp_q.push_back(4'h6);
    keys[1][2] = 1'b1;
    expect_key("clean", 5 * FRAME, lat);
    chk("clean_latency_le_4frames", lat <= 4 * FRAME, 1);
    chk("clean_held", key_held, 1);
    ack_pulse();
    chk("clean_ack_clears", key_valid, 0);
    frames(4);
    keys = '0;
    frames(5);
    chk("clean_release_held", key_held, 0);
    chk("clean_no_repeat", npres, taken);

    // Bounce on (r3,c0), then hold: one press of 0, three frames after hold starts
    align_frame();
    for (int i = 0; i < 6; i++) begin
      keys[3][0] = (i % 2 == 0);
      repeat (FRAME) @(posedge clk);
      #1;
    end
    chk("bounce_no_press", npres, taken);
    exp_q.push_back(4'h0);
    keys[3][0] = 1'b1;
    expect_key("bounce", 5 * FRAME, lat);
    chk("bounce_latency", (lat >= 3 * FRAME && lat <= 3 * FRAME + 2), 1);
    ack_pulse();
    keys = '0;
    frames(5);

    // Ghost pair on row 0; dropping one leaves code 1
    keys[0][0] = 1'b1;
    keys[0][1] = 1'b1;
    frames(6);
    chk("ghost_no_valid", key_valid, 0);
    chk("ghost_no_held", key_held, 0);
    chk("ghost_no_press", npres, taken);
    exp_q.push_back(4'h1);
    keys[0][1] = 1'b0;
    expect_key("ghost", 5 * FRAME, lat);
    ack_pulse();
    keys = '0;
    frames(5);

    // Ack on the same edge as a new accept: reload, no overrun
    align_frame();
    exp_q.push_back(4'h3);
    keys[0][2] = 1'b1;
    expect_key("pend3", 5 * FRAME, lat);
    keys = '0;
    frames(5);
    align_frame();
    exp_q.push_back(4'h9);
    keys[2][2] = 1'b1;
    repeat (3 * FRAME - 1) @(posedge clk);
    #1 key_ack = 1'b1;
    @(posedge clk);
    #1 key_ack = 1'b0;
    @(negedge clk);
    chk("ackacc_valid", key_valid, 1);
    chk("ackacc_code", key_code, 4'h9);
    chk("ackacc_overrun", overrun, 0);
    expect_key("ackacc", 4, lat);
    ack_pulse();
    keys = '0;
    frames(5);

    // Overrun: A pending, press 5 without ack
    align_frame();
    exp_q.push_back(4'hA);
    keys[0][3] = 1'b1;
    expect_key("ovr_a", 5 * FRAME, lat);
    keys = '0;
    frames(5);
    keys[1][1] = 1'b1;
    frames(5);
    chk("ovr_code_kept", key_code, 4'hA);
    chk("ovr_valid", key_valid, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_no_new", npres, taken);
    ack_pulse();
    chk("ovr_ack_clears", key_valid, 0);
    keys = '0;
    frames(5);
    chk("ovr_sticky", overrun, 1);

    // Long hold of D: single press; release needs three NONE frames
    align_frame();
    exp_q.push_back(4'hD);
    keys[3][3] = 1'b1;
    expect_key("hold_d", 5 * FRAME, lat);
    ack_pulse();
    frames(17);
    chk("hold_no_repeat", npres, taken);
    chk("hold_held", key_held, 1);
    align_frame();
    keys = '0;
    repeat (3 * FRAME - 1) @(posedge clk);
    @(negedge clk);
    chk("hold_held_before_3", key_held, 1);
    @(negedge clk);
    chk("hold_released_at_3", key_held, 0);
    frames(2);

    // Async reset mid-frame with a pending key
    align_frame();
    exp_q.push_back(4'h7);
    keys[2][0] = 1'b1;
    expect_key("pend7", 5 * FRAME, lat);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_col_n", col_n, 4'b1110);
    chk("midrst_valid", key_valid, 0);
    chk("midrst_code", key_code, 0);
    chk("midrst_held", key_held, 0);
    chk("midrst_overrun", overrun, 0);
    keys = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    frames(5);
    chk("midrst_key_lost", npres, taken);
    chk("midrst_still_idle", key_valid, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
